// File: rtl/param_updown_counter.sv
// param_updown_counter: parametrised up/down counter.
// It supports a programmable inclusive limit, a parallel load, and wrap or saturate at the boundary.
// tc is a one-cycle pulse on each boundary step. ovf is a sticky boundary flag, cleared by clr_ovf.
// Optional build macro COUNTER_PRESCALE_EN: with it defined, the counter steps once every PRESCALE enabled cycles.
module param_updown_counter #(
  parameter int unsigned WIDTH    = 5,
  parameter bit          WRAP     = 1'b1,
  parameter int unsigned RST_VAL  = 0,
  parameter int unsigned PRESCALE = 4
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic [WIDTH-1:0] data,
  input  logic             load,
  input  logic             enable,
  input  logic             up,
  input  logic [WIDTH-1:0] limit,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf
);

  // Elaboration-time sanity checks on the configuration
  if (WIDTH < 2) begin : g_bad_width
    $error("param_updown_counter: WIDTH must be >= 2");
  end
  if (PRESCALE < 2) begin : g_bad_prescale
    $error("param_updown_counter: PRESCALE must be >= 2");
  end

  logic             step;
  logic             bnd;
  logic [WIDTH-1:0] count_nx;
  logic             ovf_nx;

`ifdef COUNTER_PRESCALE_EN
  localparam int unsigned PW = $clog2(PRESCALE);

  logic [PW-1:0] psc;
  logic          psc_last;

  assign psc_last = (psc == PW'(PRESCALE - 1));

  // Prescaler: counts enabled cycles and restarts on every step, load and reset
  always_ff @(posedge clk) begin
    if (!rst_) begin
      psc <= '0;
    end else if (load) begin
      psc <= '0;
    end else if (enable) begin
      psc <= psc_last ? '0 : psc + PW'(1);
    end
  end

  assign step = enable & ~load & psc_last;
`else
  assign step = enable & ~load;
`endif

  // Next count, boundary detection and sticky flag update
  always_comb begin
    count_nx = count;
    bnd      = 1'b0;
    ovf_nx   = ovf;
    if (load) begin
      count_nx = (data > limit) ? limit : data;
    end else if (step) begin
      if (up) begin
        if (count < limit) begin
          count_nx = count + WIDTH'(1);
        end else begin
          bnd      = 1'b1;
          count_nx = WRAP ? '0 : limit;
        end
      end else begin
        if (count == '0) begin
          bnd      = 1'b1;
          count_nx = WRAP ? limit : '0;
        end else if (count > limit) begin
          // limit lowered below the count: snap down, no boundary
          count_nx = limit;
        end else begin
          count_nx = count - WIDTH'(1);
        end
      end
    end
    // a set wins over a clear in the same cycle
    if (bnd) begin
      ovf_nx = 1'b1;
    end else if (clr_ovf) begin
      ovf_nx = 1'b0;
    end
  end

  // Output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_) begin
      count <= WIDTH'(RST_VAL);
      tc    <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      count <= count_nx;
      tc    <= bnd;
      ovf   <= ovf_nx;
    end
  end

endmodule
